// File: rtl/fma16_operand_stage_if.sv
// Purpose: handshake/bus bundle between the instruction source, the operand
//          issue stage and the classification stage.
// Ports (signals):
//   in_valid/in_ready            source-side handshake
//   in_x/in_y/in_z               operands, 16 bits each
//   in_mul/in_add/in_negp/in_negz/in_roundmode   operation controls
//   out_valid/out_ready          consumer-side handshake
//   out_x..out_roundmode         buffered copy of the operation
//   out_tag                      sequence tag, TAG_W bits
// Modports: slave = the operand stage, master = the environment driving it.
interface fma16_operand_stage_if #(
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_x;
    logic [15:0]      in_y;
    logic [15:0]      in_z;
    logic             in_mul;
    logic             in_add;
    logic             in_negp;
    logic             in_negz;
    logic [1:0]       in_roundmode;

    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_x;
    logic [15:0]      out_y;
    logic [15:0]      out_z;
    logic             out_mul;
    logic             out_add;
    logic             out_negp;
    logic             out_negz;
    logic [1:0]       out_roundmode;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_x, in_y, in_z, in_mul, in_add, in_negp, in_negz, in_roundmode,
        output in_ready,
        output out_valid, out_x, out_y, out_z, out_mul, out_add, out_negp, out_negz,
        output out_roundmode, out_tag,
        input  out_ready
    );

    modport master (
        output in_valid, in_x, in_y, in_z, in_mul, in_add, in_negp, in_negz, in_roundmode,
        input  in_ready,
        input  out_valid, out_x, out_y, out_z, out_mul, out_add, out_negp, out_negz,
        input  out_roundmode, out_tag,
        output out_ready
    );
endinterface

// File: rtl/fma16_operand_stage.sv
// Purpose: registered operand-issue stage in front of fma16_classification.
//          A 2-entry skid buffer (main + skid register) tags each accepted
//          operation and presents it stably downstream. in_ready depends only
//          on registered state and flush, never on out_ready.
// Ports:
//   clk      clock, rising edge
//   reset_n  asynchronous active-low reset
//   flush    synchronous flush, discards buffered operations
//   io       fma16_operand_stage_if.slave (in_* source side, out_* consumer side)
module fma16_operand_stage #(
    parameter int unsigned TAG_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    fma16_operand_stage_if.slave  io
);

    typedef struct packed {
        logic [15:0]      x;
        logic [15:0]      y;
        logic [15:0]      z;
        logic             mul;
        logic             add;
        logic             negp;
        logic             negz;
        logic [1:0]       roundmode;
        logic [TAG_W-1:0] tag;
    } op_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    op_t              r_main;
    op_t              r_skid;
    logic [TAG_W-1:0] r_tag_cnt;

    op_t              w_in_op;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    // Incoming bundle stamped with the current sequence tag
    always_comb begin
        w_in_op           = '0;
        w_in_op.x         = io.in_x;
        w_in_op.y         = io.in_y;
        w_in_op.z         = io.in_z;
        w_in_op.mul       = io.in_mul;
        w_in_op.add       = io.in_add;
        w_in_op.negp      = io.in_negp;
        w_in_op.negz      = io.in_negz;
        w_in_op.roundmode = io.in_roundmode;
        w_in_op.tag       = r_tag_cnt;
    end

    assign w_in_ready  = ~flush & (r_state != ST_FULL);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_accept    = io.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & io.out_ready;

    // Next-state and register load selection; flush overrides the handshake
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && !w_pop) begin
                        w_state_nxt = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_pop && !w_accept) begin
                        w_state_nxt = ST_EMPTY;
                    end else if (w_accept && w_pop) begin
                        w_load_main = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // State, storage and tag counter (counter survives flush)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_EMPTY;
            r_main    <= '0;
            r_skid    <= '0;
            r_tag_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : w_in_op;
            end
            if (w_load_skid) begin
                r_skid <= w_in_op;
            end
            if (w_accept) begin
                r_tag_cnt <= r_tag_cnt + TAG_W'(1);
            end
        end
    end

    assign io.in_ready      = w_in_ready;
    assign io.out_valid     = w_out_valid;
    assign io.out_x         = r_main.x;
    assign io.out_y         = r_main.y;
    assign io.out_z         = r_main.z;
    assign io.out_mul       = r_main.mul;
    assign io.out_add       = r_main.add;
    assign io.out_negp      = r_main.negp;
    assign io.out_negz      = r_main.negz;
    assign io.out_roundmode = r_main.roundmode;
    assign io.out_tag       = r_main.tag;

endmodule

// File: tb/tb_fma16_operand_stage.sv
// Purpose: scoreboard bench for fma16_operand_stage. The reference model is a
//          FIFO of at most two entries plus a wrapping tag counter; a monitor
//          at each falling edge checks handshake flags and the presented
//          bundle against the head of that FIFO.
// Ports: none (top-level bench).
module tb_fma16_operand_stage;

    localparam int unsigned TAG_W = 4;

    logic clk;
    logic reset_n;
    logic flush;

    fma16_operand_stage_if #(.TAG_W(TAG_W)) bus ();

    fma16_operand_stage #(.TAG_W(TAG_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .io      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Expected bundle: {x, y, z, mul, add, negp, negz, roundmode, tag}
    logic [53+TAG_W:0] sb_q[$];
    logic [TAG_W-1:0]  model_tag = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [53+TAG_W:0] dut_bundle();
        return {bus.out_x, bus.out_y, bus.out_z, bus.out_mul, bus.out_add,
                bus.out_negp, bus.out_negz, bus.out_roundmode, bus.out_tag};
    endfunction

    // Monitor / reference model, evaluated mid-cycle
    always @(negedge clk) begin
        if (reset_n) begin
            logic exp_ir;
            logic exp_ov;
            exp_ir = !flush && (sb_q.size() < 2);
            exp_ov = (sb_q.size() > 0);
            chk("in_ready", 64'(bus.in_ready), 64'(exp_ir));
            chk("out_valid", 64'(bus.out_valid), 64'(exp_ov));
            if (exp_ov && bus.out_valid) begin
                chk("bundle", 64'(dut_bundle()), 64'(sb_q[0]));
            end
            if (exp_ov && bus.out_ready) begin
                void'(sb_q.pop_front());
            end
            if (flush) begin
                sb_q.delete();
            end else if (exp_ir && bus.in_valid) begin
                sb_q.push_back({bus.in_x, bus.in_y, bus.in_z, bus.in_mul, bus.in_add,
                                bus.in_negp, bus.in_negz, bus.in_roundmode, model_tag});
                model_tag = model_tag + TAG_W'(1);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] z, input logic [3:0] ctl, input logic [1:0] rm);
        bus.in_valid     = v;
        bus.in_x         = x;
        bus.in_y         = y;
        bus.in_z         = z;
        {bus.in_mul, bus.in_add, bus.in_negp, bus.in_negz} = ctl;
        bus.in_roundmode = rm;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 16'h0, 16'h0, 16'h0, 4'h0, 2'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_out_x", 64'(bus.out_x), 64'd0);
        chk("rst_out_ctl", 64'({bus.out_mul, bus.out_add, bus.out_negp, bus.out_negz, bus.out_roundmode}), 64'd0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Single operation
        next_cycle();
        bus.out_ready = 1'b1;
        drive(1'b1, 16'h3C00, 16'h4000, 16'h0000, 4'b1100, 2'd0);
        next_cycle();
        idle();
        chk("single_out_x", 64'(bus.out_x), 64'h3C00);
        chk("single_out_tag", 64'(bus.out_tag), 64'd0);
        next_cycle();
        chk("single_drain", 64'(bus.out_valid), 64'd0);

        // Backpressure: fill both entries, then release
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h0001, 16'h1111, 16'h2222, 4'b1010, 2'd1);
        next_cycle();
        drive(1'b1, 16'h0002, 16'h3333, 16'h4444, 4'b0101, 2'd2);
        next_cycle();
        drive(1'b1, 16'h0003, 16'h5555, 16'h6666, 4'b1111, 2'd3);
        chk("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("bp_hold_x", 64'(bus.out_x), 64'h0001);
        next_cycle();
        idle();
        chk("bp_still_x", 64'(bus.out_x), 64'h0001);
        bus.out_ready = 1'b1;
        next_cycle();
        chk("bp_second_x", 64'(bus.out_x), 64'h0002);
        chk("bp_second_tag", 64'(bus.out_tag), 64'd2);
        chk("bp_ready_back", 64'(bus.in_ready), 64'd1);
        next_cycle();

        // Streaming 20 back-to-back ops (tags wrap)
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(i), 16'(i * 3), 16'(i * 7), 4'(i), 2'(i));
            next_cycle();
        end
        idle();
        next_cycle();

        // Flush while FULL with in_valid held high
        bus.out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 16'h1, 16'h2, 4'b1100, 2'd0);
        next_cycle();
        drive(1'b1, 16'hBBBB, 16'h3, 16'h4, 4'b1100, 2'd1);
        next_cycle();
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd0);
        next_cycle();
        flush = 1'b0;
        idle();
        chk("flush_empty", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        drive(1'b1, 16'hCCCC, 16'h5, 16'h6, 4'b0011, 2'd3);
        next_cycle();
        idle();
        chk("flush_tag_continues", 64'(bus.out_tag), 64'(model_tag - TAG_W'(1)));
        next_cycle();

        // Async reset pulse with a full buffer
        bus.out_ready = 1'b0;
        drive(1'b1, 16'h1234, 16'h0, 16'h0, 4'b1000, 2'd0);
        next_cycle();
        next_cycle();
        reset_n = 1'b0;
        sb_q.delete();
        model_tag = '0;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_out_tag", 64'(bus.out_tag), 64'd0);
        #1;
        reset_n = 1'b1;
        idle();
        #1;
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        next_cycle();

        // Randomized traffic with occasional flush
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, 16'($urandom), 16'($urandom), 16'($urandom),
                  4'($urandom), 2'($urandom));
            bus.out_ready = ($urandom % 3) != 0;
            flush = ($urandom % 25) == 0;
            next_cycle();
        end
        flush = 1'b0;
        idle();
        bus.out_ready = 1'b1;
        repeat (4) next_cycle();
        chk("final_drained", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
